// File: rtl/pp_mult_pkg.sv
// Shared types and constants for the partial-product multiplier sequencer.
package pp_mult_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_BPC   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of accumulation cycles needed for one product.
  function automatic int steps_f(input int width, input int bpc);
    return width / bpc;
  endfunction

endpackage

// File: rtl/pp_chunk_sum.sv
// Shared partial-product slice: sums BPC gated, shifted copies of the
// multiplicand. Row j is a << (base + j), kept only when b_slice[j] is set.
module pp_chunk_sum
  import pp_mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int BPC   = DEF_BPC,
  parameter int SHW   = $clog2(2 * DEF_WIDTH)
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [BPC-1:0]     b_slice,
  input  logic [SHW-1:0]     base,
  output logic [2*WIDTH-1:0] sum
);

  localparam int PW = 2 * WIDTH;

  logic [PW-1:0] sum_s;

  // Add up the selected rows; zero-extended so no bits are lost.
  always_comb begin
    sum_s = {PW{1'b0}};
    for (int j = 0; j < BPC; j++) begin
      if (b_slice[j]) begin
        sum_s = sum_s + (PW'(a) << (base + SHW'(j)));
      end else begin
        sum_s = sum_s;
      end
    end
  end

  assign sum = sum_s;

endmodule

// File: rtl/pp_mult_sequencer.sv
// Iterative unsigned multiplier: consumes BPC multiplier bits per cycle
// through one shared partial-product slice and accumulates a 2*WIDTH product.
module pp_mult_sequencer
  import pp_mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int BPC   = DEF_BPC
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               busy
);

  localparam int STEPS = steps_f(WIDTH, BPC);
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int PW    = 2 * WIDTH;
  localparam int SHW   = $clog2(PW);
  localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

  generate
    if ((BPC < 1) || ((WIDTH % BPC) != 0)) begin : g_bad_bpc
      $error("pp_mult_sequencer: BPC must divide WIDTH");
    end
  endgenerate

  state_t          state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [PW-1:0]    acc_r;
  logic [CW-1:0]    step_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             busy_r;

  logic [SHW-1:0]   base_s;
  logic [BPC-1:0]   b_slice_s;
  logic [PW-1:0]    chunk_sum_s;

  // Current multiplier chunk and its bit offset inside the product.
  assign base_s    = SHW'(step_r) * SHW'(BPC);
  assign b_slice_s = BPC'(b_r >> base_s);

  pp_chunk_sum #(
    .WIDTH (WIDTH),
    .BPC   (BPC),
    .SHW   (SHW)
  ) u_chunk (
    .a       (a_r),
    .b_slice (b_slice_s),
    .base    (base_s),
    .sum     (chunk_sum_s)
  );

  // Control FSM, step counter, operand latches and accumulator; handshake
  // outputs are registered alongside the state so they never see inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      acc_r       <= {PW{1'b0}};
      step_r      <= {CW{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else if (clear) begin
      state_r     <= IDLE;
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      acc_r       <= {PW{1'b0}};
      step_r      <= {CW{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r        <= in_a;
            b_r        <= in_b;
            acc_r      <= {PW{1'b0}};
            step_r     <= {CW{1'b0}};
            state_r    <= RUN;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
          end else begin
            state_r    <= IDLE;
          end
        end
        RUN: begin
          acc_r <= acc_r + chunk_sum_s;
          if (step_r == LAST_STEP) begin
            step_r      <= {CW{1'b0}};
            state_r     <= DONE;
            out_valid_r <= 1'b1;
          end else begin
            step_r      <= step_r + CW'(1'b1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            in_ready_r  <= 1'b1;
          end else begin
            state_r     <= DONE;
          end
        end
        default: begin
          state_r     <= IDLE;
          acc_r       <= {PW{1'b0}};
          step_r      <= {CW{1'b0}};
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign out_p     = acc_r;

endmodule

// File: tb/tb_pp_mult_sequencer.sv
// Self-checking bench for pp_mult_sequencer: directed vectors with literal
// expectations plus a transaction-level model compared every cycle.
module tb_pp_mult_sequencer;

  localparam int W     = 16;
  localparam int STEPS = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [2*W-1:0] out_p;
  logic          busy;

  int n_chk = 0;
  int n_err = 0;

  pp_mult_sequencer #(.WIDTH(W), .BPC(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .busy      (busy)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: a job is either absent, counting cycles since accept,
  // or holding its product until the consumer takes it.
  logic        m_busy  = 1'b0;
  logic        m_valid = 1'b0;
  int          m_cnt   = 0;
  logic [31:0] m_prod  = 32'd0;
  logic [31:0] m_hold  = 32'd0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || clear) begin
      m_busy = 1'b0; m_valid = 1'b0; m_cnt = 0; m_hold = 32'd0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy = 1'b1; m_cnt = 0; m_prod = 32'(in_a) * 32'(in_b);
      end
    end else if (!m_valid) begin
      m_cnt++;
      if (m_cnt == STEPS) m_valid = 1'b1;
    end else if (out_ready) begin
      m_busy = 1'b0; m_valid = 1'b0; m_hold = m_prod;
    end
  end

  // Per-cycle comparison against the model, sampled after the edge settles.
  always @(posedge clk) begin
    #2;
    chk("in_ready", in_ready, !m_busy);
    chk("busy", busy, m_busy);
    chk("out_valid", out_valid, m_valid);
    if (m_valid) chk("out_p_valid", out_p, m_prod);
    else if (!m_busy) chk("out_p_idle", out_p, m_hold);
  end

  // One operation: present operands, wait for accept, measure latency.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] exp, input string nm);
    int cnt;
    int lat;
    @(negedge clk);
    in_a = a; in_b = b; in_valid = 1'b1;
    cnt = 0;
    while (!in_ready && cnt < 50) begin @(negedge clk); cnt++; end
    chk({nm, "_accept_wait"}, 64'(cnt < 50), 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    chk({nm, "_latency"}, 64'(lat), 64'(STEPS));
    chk({nm, "_p"}, out_p, 64'(exp));
  endtask

  initial begin
    logic [15:0] ra, rb;
    #12;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_out_p", out_p, 64'd0);
    @(negedge clk); rst_n = 1'b1;

    // Basic, then in_ready in the cycle after the handoff edge.
    run_op(16'd3, 16'd5, 32'd15, "basic");
    @(posedge clk); @(negedge clk);
    chk("basic_ready_after", in_ready, 1'b1);
    chk("basic_held_p", out_p, 64'd15);

    run_op(16'hFFFF, 16'hFFFF, 32'hFFFE0001, "full");
    run_op(16'h1234, 16'h0000, 32'h00000000, "zero");
    run_op(16'h8000, 16'h8001, 32'h40008000, "extreme");

    // Clear in IDLE with in_valid high must not accept.
    @(posedge clk); @(negedge clk);
    clear = 1'b1; in_valid = 1'b1; in_a = 16'd2; in_b = 16'd2;
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0;
    chk("clear_idle_busy", busy, 1'b0);
    chk("clear_idle_p", out_p, 64'd0);

    // Backpressure: result held 10 cycles, operand pulses ignored.
    out_ready = 1'b0;
    run_op(16'h0102, 16'h0304, 32'h00030A08, "bp");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = i[0]; in_a = 16'hAAAA; in_b = 16'h5555;
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_p_stable", out_p, 64'h00030A08);
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("bp_released", in_ready, 1'b1);

    // Clear during step 2: back to IDLE next cycle, no result.
    @(negedge clk);
    in_a = 16'h00FF; in_b = 16'h0F0F; in_valid = 1'b1;
    @(posedge clk); @(negedge clk); in_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("abort_ready", in_ready, 1'b1);
    chk("abort_busy", busy, 1'b0);
    chk("abort_valid", out_valid, 1'b0);
    chk("abort_p", out_p, 64'd0);
    repeat (6) @(negedge clk);
    chk("abort_no_valid", out_valid, 1'b0);
    run_op(16'd7, 16'd9, 32'd63, "after_abort");

    // Async reset mid-RUN: outputs return immediately, no clock edge.
    @(negedge clk);
    in_a = 16'h1111; in_b = 16'h2222; in_valid = 1'b1;
    @(posedge clk); @(negedge clk); in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", in_ready, 1'b1);
    chk("arst_busy", busy, 1'b0);
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_out_p", out_p, 64'd0);
    @(negedge clk); rst_n = 1'b1;

    // Random pairs against arithmetic reference.
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      run_op(ra, rb, 32'(ra) * 32'(rb), "rand");
    end

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
